// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: two request ports with their acks and read data.
// master = the two requesters, slave = the arbiter.
interface dmem_arbiter_if;
    localparam int unsigned DW = 32;

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [DW-1:0] addr0;
    logic [DW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, one access in flight: IDLE -> ACCESS (ACCESS_CYCLES) -> RESP.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus,
    output logic          busy_o,
    output logic [31:0]   mem_address_o,
    output logic [31:0]   write_data_o,
    output logic          sig_mem_read_o,
    output logic          sig_mem_write_o,
    input  logic [31:0]   read_data_i
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          idx_q;
    logic          we_q;
    logic          busy_q;
    logic          rd_q;
    logic          wr_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          any_req_c;
    logic          win_idx_d;
    logic          win_we_d;
    logic [DW-1:0] win_addr_d;
    logic [DW-1:0] win_wdata_d;

    assign any_req_c = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
    // rr_q names the port that wins the next tie; it flips away from every grantee.
    logic rr_q;
    assign win_idx_d = (bus.req0 & bus.req1) ? rr_q : bus.req1;
`else
    assign win_idx_d = bus.req1 & ~bus.req0;
`endif

    assign win_we_d    = win_idx_d ? bus.we1    : bus.we0;
    assign win_addr_d  = win_idx_d ? bus.addr1  : bus.addr0;
    assign win_wdata_d = win_idx_d ? bus.wdata1 : bus.wdata0;

    // Arbitration FSM; every output comes straight from a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        state_q <= ACCESS;
                        idx_q   <= win_idx_d;
                        we_q    <= win_we_d;
                        addr_q  <= win_addr_d;
                        wdata_q <= win_wdata_d;
                        cnt_q   <= CW'(ACCESS_CYCLES - 1);
                        rd_q    <= ~win_we_d;
                        wr_q    <= win_we_d;
                        busy_q  <= 1'b1;
`ifdef DMEM_ARB_RR_EN
                        rr_q    <= ~win_idx_d;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ack0_q  <= ~idx_q;
                        ack1_q  <= idx_q;
                        // Memory data is combinational on the held address; capture on the last edge.
                        if (!we_q) begin
                            if (idx_q) rdata1_q <= read_data_i;
                            else       rdata0_q <= read_data_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign busy_o          = busy_q;
    assign mem_address_o   = addr_q;
    assign write_data_o    = wdata_q;
    assign sig_mem_read_o  = rd_q;
    assign sig_mem_write_o = wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Instance A uses ACCESS_CYCLES=1, instance B uses ACCESS_CYCLES=3; honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    localparam int unsigned AC_A = 1;
    localparam int unsigned AC_B = 3;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if ifa ();
    dmem_arbiter_if ifb ();

    logic        busy_a, rd_a, wr_a, busy_b, rd_b, wr_b;
    logic [31:0] addr_a, wd_a, rdd_a, addr_b, wd_b, rdd_b;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    dmem_arbiter #(.ACCESS_CYCLES(AC_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa), .busy_o(busy_a),
        .mem_address_o(addr_a), .write_data_o(wd_a),
        .sig_mem_read_o(rd_a), .sig_mem_write_o(wr_a), .read_data_i(rdd_a)
    );

    dmem_arbiter #(.ACCESS_CYCLES(AC_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb), .busy_o(busy_b),
        .mem_address_o(addr_b), .write_data_o(wd_b),
        .sig_mem_read_o(rd_b), .sig_mem_write_o(wr_b), .read_data_i(rdd_b)
    );

    always #5 clk = ~clk;

    // Data memories: combinational read, write on the clock edge while the write strobe is high.
    assign rdd_a = mem_a[addr_a[5:0]];
    assign rdd_b = mem_b[addr_b[5:0]];
    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (wr_a) mem_a[addr_a[5:0]] <= wd_a;
            if (wr_b) mem_b[addr_b[5:0]] <= wd_b;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model of instance A at transaction level.
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rd  [2];
    int          pref;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int predict(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return pref;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    task automatic model_apply(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (we) ref_mem[a[5:0]] = d;
        else    exp_rd[p] = ref_mem[a[5:0]];
        pref = 1 - p;
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            ifa.req0 = r; ifa.we0 = we; ifa.addr0 = a; ifa.wdata0 = d;
        end else begin
            ifa.req1 = r; ifa.we1 = we; ifa.addr1 = a; ifa.wdata1 = d;
        end
    endtask

    task automatic wait_any_ack(output int port, output int cyc, output int nrd, output int nwr,
                                output logic [31:0] sa, output logic [31:0] sw);
        port = -1; cyc = 0; nrd = 0; nwr = 0; sa = '0; sw = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (rd_a) nrd++;
            if (wr_a) nwr++;
            if (rd_a || wr_a) begin
                sa = addr_a;
                sw = wd_a;
            end
            check("ack_onehot", 32'(ifa.ack0 & ifa.ack1), 32'd0);
            if (ifa.ack0) begin port = 0; break; end
            if (ifa.ack1) begin port = 1; break; end
        end
    endtask

    task automatic check_rdata(input string tag);
        check({tag, "_rdata0"}, ifa.rdata0, exp_rd[0]);
        check({tag, "_rdata1"}, ifa.rdata1, exp_rd[1]);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check(tag, 32'({ifa.ack0, ifa.ack1, busy_a, rd_a, wr_a}), 32'd0);
    endtask

    task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        int port, cyc, nrd, nwr;
        logic [31:0] sa, sw;
        drive(p, 1'b1, we, a, d);
        wait_any_ack(port, cyc, nrd, nwr, sa, sw);
        drive(p, 1'b0, we, a, d);
        check("txn_port", 32'(port), 32'(p));
        check("txn_latency", 32'(cyc), 32'(AC_A + 1));
        check("txn_rd_cycles", 32'(nrd), we ? 32'd0 : 32'(AC_A));
        check("txn_wr_cycles", 32'(nwr), we ? 32'(AC_A) : 32'd0);
        check("txn_addr", sa, a);
        if (we) check("txn_wdata", sw, d);
        model_apply(p, we, a, d);
        check_rdata("txn");
        check_idle("txn_idle_after_ack");
    endtask

    task automatic pair(input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        int port, cyc, nrd, nwr, first;
        logic [31:0] sa, sw;
        first = predict(1'b1, 1'b1);
        drive(0, 1'b1, we0, a0, d0);
        drive(1, 1'b1, we1, a1, d1);
        for (int k = 0; k < 2; k++) begin
            int exp_p;
            exp_p = (k == 0) ? first : 1 - first;
            wait_any_ack(port, cyc, nrd, nwr, sa, sw);
            check($sformatf("pair_port_%0d", k), 32'(port), 32'(exp_p));
            if (exp_p == 0) begin
                drive(0, 1'b0, we0, a0, d0);
                check("pair_addr0", sa, a0);
                model_apply(0, we0, a0, d0);
            end else begin
                drive(1, 1'b0, we1, a1, d1);
                check("pair_addr1", sa, a1);
                model_apply(1, we1, a1, d1);
            end
            if (k == 0) check("pair_first_latency", 32'(cyc), 32'(AC_A + 1));
            check_rdata("pair");
        end
        check_idle("pair_idle_after_ack");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    initial begin
        int port, cyc, nrd, nwr, nbusy, nack;
        logic [31:0] sa, sw;

        rst = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        ifb.req0 = 1'b0; ifb.we0 = 1'b0; ifb.addr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 1'b0; ifb.we1 = 1'b0; ifb.addr1 = '0; ifb.wdata1 = '0;
        pref = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // Preload both memories while reset is held; mem[3] gets 0x11.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 6'(i);
            pl_data = (i == 3) ? 32'h11 : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;

        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_strobes_a", 32'({rd_a, wr_a}), 32'd0);
        check("rst_addr_a", addr_a, 32'd0);
        check("rst_wdata_a", wd_a, 32'd0);
        check("rst_acks_a", 32'({ifa.ack0, ifa.ack1}), 32'd0);
        check_rdata("rst");
        check("rst_busy_b", 32'(busy_b), 32'd0);

        rst = 1'b0;
        @(negedge clk);

        // Single read of preloaded word.
        txn(0, 1'b0, 32'd3, 32'd0);
        check("read3_rdata0", ifa.rdata0, 32'h11);

        // Port 1 write then readback.
        txn(1, 1'b1, 32'd1, 32'd8);
        txn(1, 1'b0, 32'd1, 32'd0);
        check("readback_rdata1", ifa.rdata1, 32'd8);
        check("readback_rdata0_kept", ifa.rdata0, 32'h11);

        // Contention: both ports hold reads for four grants.
        drive(0, 1'b1, 1'b0, 32'd3, '0);
        drive(1, 1'b1, 1'b0, 32'd1, '0);
        for (int k = 0; k < 4; k++) begin
            int exp_p;
            exp_p = predict(1'b1, 1'b1);
            wait_any_ack(port, cyc, nrd, nwr, sa, sw);
            check($sformatf("contend_port_%0d", k), 32'(port), 32'(exp_p));
            model_apply(exp_p, 1'b0, (exp_p == 1) ? 32'd1 : 32'd3, '0);
            check_rdata("contend");
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 32'd3, '0);
                drive(1, 1'b0, 1'b0, 32'd1, '0);
            end
        end
        check_idle("contend_idle");

        // Requester drops req during ACCESS; access still completes once.
        drive(0, 1'b1, 1'b0, 32'd7, '0);
        @(negedge clk);
        check("drop_in_access", 32'(rd_a), 32'd1);
        drive(0, 1'b0, 1'b0, 32'd7, '0);
        @(negedge clk);
        check("drop_ack0", 32'(ifa.ack0), 32'd1);
        model_apply(0, 1'b0, 32'd7, '0);
        check_rdata("drop");
        nack = 0; nbusy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nack  += int'(ifa.ack0) + int'(ifa.ack1);
            nbusy += int'(busy_a) + int'(rd_a) + int'(wr_a);
        end
        check("drop_no_second_ack", 32'(nack), 32'd0);
        check("drop_no_second_access", 32'(nbusy), 32'd0);

        // Stretched write on the ACCESS_CYCLES=3 instance.
        ifb.req1 = 1'b1; ifb.we1 = 1'b1; ifb.addr1 = 32'd12; ifb.wdata1 = 32'd13;
        cyc = 0; nwr = 0; nbusy = 0; sa = '0; sw = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (wr_b) begin nwr++; sa = addr_b; sw = wd_b; end
            if (busy_b) nbusy++;
            if (ifb.ack1) break;
        end
        ifb.req1 = 1'b0;
        check("stretch_latency", 32'(cyc), 32'(AC_B + 1));
        check("stretch_wr_cycles", 32'(nwr), 32'(AC_B));
        check("stretch_busy_cycles", 32'(nbusy), 32'(AC_B + 1));
        check("stretch_addr", sa, 32'd12);
        check("stretch_wdata", sw, 32'd13);
        @(negedge clk);
        check("stretch_mem", mem_b[12], 32'd13);
        check("stretch_idle", 32'({busy_b, ifb.ack1, wr_b}), 32'd0);

        // Reset asserted in the second of three ACCESS cycles.
        ifb.req0 = 1'b1; ifb.we0 = 1'b0; ifb.addr0 = 32'd5;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_in_access", 32'({busy_b, rd_b}), 32'd3);
        rst = 1'b1;
        #1;
        check("rstmid_async_drop", 32'({busy_b, rd_b, wr_b}), 32'd0);
        check("rstmid_addr", addr_b, 32'd0);
        ifb.req0 = 1'b0;
        pref = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nack = 0; nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nack  += int'(ifb.ack0) + int'(ifb.ack1);
            nbusy += int'(busy_b);
        end
        check("rstmid_no_ack", 32'(nack), 32'd0);
        check("rstmid_idle", 32'(nbusy), 32'd0);
        check("rstmid_rdata_b", ifb.rdata0, 32'd0);
        check_rdata("rst_a");

        // Random traffic on instance A.
        for (int n = 0; n < 40; n++) begin
            int mode, gap;
            mode = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
            if (mode == 2) begin
                pair(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                     1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            end else begin
                txn(mode, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1, meaning: number of clock cycles the memory strobes are held per access (legal range 1..15).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request from port 0 (CPU load/store) / port 1 (loader/debug).
REQ-005 we0 / we1  input  1  1 = write, 0 = read, for the corresponding port.
REQ-006 addr0 / addr1  input  32  word address for the corresponding port.
REQ-007 wdata0 / wdata1  input  32  write data for the corresponding port.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse for the corresponding port.
REQ-009 rdata0 / rdata1  output  32  registered read result for the corresponding port.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 mem_address  output  32  address to the data memory.
REQ-012 write_data  output  32  write data to the data memory.
REQ-013 sig_mem_read / sig_mem_write  output  1  memory read / write strobes.
REQ-014 read_data  input  32  combinational read data returned by the data memory.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; at most one access is in flight.
REQ-016 In IDLE with any request high, the FSM latches the winner's index, we, addr and wdata, then moves to ACCESS at the next edge; with no request it stays in IDLE.
REQ-017 In ACCESS, the FSM drives mem_address and write_data from the latched values for exactly ACCESS_CYCLES cycles.
REQ-018 During ACCESS, exactly one of sig_mem_read or sig_mem_write is high, per the latched we.
REQ-019 A down-counter loaded with ACCESS_CYCLES-1 times the ACCESS state; the FSM leaves ACCESS for RESP when the counter reads 0.
REQ-020 On a read, read_data is registered into the winner's rdata on the final ACCESS edge; the other port's rdata, and any rdata on a write, holds its value.
REQ-021 In RESP, the winner's ack is high for exactly one cycle, strobes are low, and the FSM returns to IDLE.
REQ-022 Latency from the req-sampling edge to ack high is ACCESS_CYCLES+1 cycles; peak throughput is one access per ACCESS_CYCLES+2 cycles.
REQ-023 A requester holds req, we, addr and wdata stable until its ack; a req still high in the IDLE cycle after ack is a new request.
REQ-024 Deasserting req during ACCESS or RESP does not abort the access; it completes and acks normally.
REQ-025 Outside ACCESS, sig_mem_read = sig_mem_write = 0; mem_address and write_data hold their last values.
REQ-026 ack0 and ack1 are never high in the same cycle.

Reset
REQ-027 Asserting reset, including mid-access, immediately sets: FSM to IDLE; strobes, ack0, ack1 and busy to 0; mem_address, write_data, rdata0 and rdata1 to 0; counter to 0; round-robin pointer to port 0.
REQ-028 An access interrupted by reset is dropped without an ack; its requester re-requests.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the port not granted last wins; the pointer updates at each grant.
REQ-030 Macro DMEM_ARB_RR_EN undefined: fixed priority; port 0 always wins simultaneous requests; no pointer register exists.

Verification
REQ-031 Single read: mem[3]=0x11 preloaded, req0=1, we0=0, addr0=3, ACCESS_CYCLES=1 -> sig_mem_read high for 1 cycle, ack0 two cycles after sampling, rdata0=0x11.
REQ-032 Single write then readback: port 1 writes 8 to address 1, then reads address 1 -> sig_mem_write high 1 cycle, ack1 pulse; readback gives rdata1=8 and rdata0 unchanged.
REQ-033 Contention: req0 and req1 both held high for 4 accesses -> with DMEM_ARB_RR_EN, acks alternate 0,1,0,1; without it, port 0 acks continuously and port 1 is starved while req0 stays high.
REQ-034 Stretch: ACCESS_CYCLES=3, write 13 to address 12 -> sig_mem_write high exactly 3 cycles, ack1 four cycles after sampling, busy high 4 cycles.
REQ-035 Reset mid-ACCESS: reset asserted in the 2nd of 3 ACCESS cycles -> strobes and busy drop without waiting for a clock, no ack, and the FSM is in IDLE after reset release.
REQ-036 Early req drop: req0 deasserted during ACCESS -> access completes, ack0 pulses once, and no second access occurs.
